msg_framer: RTL and testbench
=============================

Name: msg_framer

Overview:
- Upstream stage of the message-tracking FSM: converts a request (header byte plus payload length) and a payload byte stream into a framed beat stream on valid/head/tail/data.
- Each message is exactly one head beat carrying the header, req_len data beats, then one tail beat carrying an XOR checksum.
- Output encoding matches the downstream tracker's IDLE/HEAD/DATA/TAIL protocol.

Parameters:
- DATA_WIDTH, 8, width of header, payload and output data.
- LEN_WIDTH, 4, width of req_len; maximum payload is 2^LEN_WIDTH-1 beats.
- GAP_CYCLES, 0, forced idle cycles after each tail beat before the next request is accepted (0..15).

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  request accepted when req_valid & req_ready at the clock edge.
- req_hdr  input  DATA_WIDTH  header byte for the head beat.
- req_len  input  LEN_WIDTH  number of data beats (0 allowed).
- pay_valid  input  1  payload byte present.
- pay_ready  output  1  payload byte consumed when pay_valid & pay_ready at the edge.
- pay_data  input  DATA_WIDTH  payload byte.
- out_hold  input  1  downstream stall.
- valid  output  1  beat valid (registered).
- head  output  1  head beat marker (registered).
- tail  output  1  tail beat marker (registered).
- data  output  DATA_WIDTH  beat data (registered).
- msg_done  output  1  one-cycle pulse coincident with the tail beat.

Behaviour:
- Reset is synchronous, active-high, one clock: state=IDLE; valid, head, tail, msg_done=0; data=0; counter, checksum and gap counter cleared.
- Reset asserted mid-message aborts the message: no tail is produced and no partial state survives.
- States and transitions:
  - IDLE -> HEAD on request accept.
  - HEAD -> DATA if the latched length is nonzero, else HEAD -> TAIL.
  - DATA -> TAIL after the last data beat.
  - TAIL -> GAP if GAP_CYCLES>0, else TAIL -> IDLE.
  - GAP -> IDLE after GAP_CYCLES cycles.
- req_ready = (state==IDLE); combinational, no dependence on req_valid.
  - On accept: latch req_hdr and req_len, set checksum=req_hdr.
- HEAD state: if out_hold=0 at the edge, register valid=1, head=1, tail=0, data=hdr, then advance. If out_hold=1, register valid=0 and stay (beat retried).
- DATA state:
  - pay_ready = (state==DATA) & ~out_hold.
  - On a pop: register valid=1, head=0, tail=0, data=pay_data; checksum ^= pay_data; decrement remaining count; leave for TAIL when the count reaches 0.
  - No pop (pay_valid=0 or hold): register valid=0 (bubble) and stay in DATA.
- TAIL state: if out_hold=0, register valid=1, tail=1, head=0, data=checksum, msg_done=1, then advance. If out_hold=1, valid=0 and stay.
- IDLE and GAP states: valid, head, tail, msg_done=0; data holds its last value.
- Latency: request accepted at edge N -> head beat visible after edge N+1 (earliest).
  - With no stalls, a message occupies req_len+2 consecutive valid cycles.
  - The next head comes no earlier than 2+GAP_CYCLES cycles after the tail.
- Output invariants: head and tail are never 1 in the same cycle; head/tail/msg_done are 0 whenever valid=0.
- Only the HEAD and TAIL states look at out_hold; DATA also gates pay_ready with it.
- Request inputs are ignored outside IDLE. Payload inputs are ignored outside DATA.

Test Plan:
- Basic message: reset 2 cycles; req_hdr=0xA5, req_len=2; payload 0x01, 0x02 always valid -> beats (h)0xA5, 0x01, 0x02, (t)0xA6 on consecutive cycles; msg_done with the tail; req_ready low from the accept cycle until after the tail.
- Zero length: req_hdr=0x3C, req_len=0 -> head 0x3C immediately followed by tail 0x3C; pay_ready never asserted.
- Stalls:
  - Setup: req_len=3, pay_valid low for 2 cycles mid-message, out_hold high during TAIL for 1 cycle.
  - Required: bubbles with valid=0, no beat lost or duplicated, checksum correct, tail appears one cycle late.
- Back-to-back: GAP_CYCLES=0, req_valid held high with two requests -> second head 2 cycles after the first tail. Repeat with GAP_CYCLES=3 -> 5 cycles.
- Reset mid-DATA: reset high for 1 cycle after the second data beat of a len=4 message -> valid=0 next cycle, no tail, req_ready=1; a fresh message then frames correctly.
- Max length: req_len=15 -> 17 valid beats; count does not wrap; tail present.

Source files
------------

// File: rtl/msg_framer.sv
// msg_framer: turns a request (header + payload length) and a payload byte
// stream into framed head / data / tail beats, ending each message with an
// XOR checksum of the header and all payload bytes.
module msg_framer #(
   parameter int DATA_WIDTH = 8,
   parameter int LEN_WIDTH  = 4,
   parameter int GAP_CYCLES = 0
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic [DATA_WIDTH-1:0] req_hdr,
   input  logic [LEN_WIDTH-1:0]  req_len,
   input  logic                  pay_valid,
   output logic                  pay_ready,
   input  logic [DATA_WIDTH-1:0] pay_data,
   input  logic                  out_hold,
   output logic                  valid,
   output logic                  head,
   output logic                  tail,
   output logic [DATA_WIDTH-1:0] data,
   output logic                  msg_done
);

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_HEAD = 3'd1,
      ST_DATA = 3'd2,
      ST_TAIL = 3'd3,
      ST_GAP  = 3'd4
   } state_t;

   // The gap counter runs from GAP_CYCLES-1 down to 0, so GAP lasts exactly
   // GAP_CYCLES cycles before the framer returns to IDLE.
   localparam logic [3:0] GAP_LOAD = (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;
   localparam logic [LEN_WIDTH-1:0] LEN_ONE = {{(LEN_WIDTH-1){1'b0}}, 1'b1};

   state_t                state_r;
   logic [DATA_WIDTH-1:0] hdr_r;
   logic [LEN_WIDTH-1:0]  remain_r;
   logic [DATA_WIDTH-1:0] csum_r;
   logic [3:0]            gap_r;
   logic                  pop_s;

   // Handshake readiness is decoded straight from the state.
   assign req_ready = (state_r == ST_IDLE);
   assign pay_ready = (state_r == ST_DATA) & ~out_hold;
   assign pop_s     = pay_ready & pay_valid;

   // Framing FSM with registered beat outputs.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_r  <= ST_IDLE;
         hdr_r    <= '0;
         remain_r <= '0;
         csum_r   <= '0;
         gap_r    <= 4'd0;
         valid    <= 1'b0;
         head     <= 1'b0;
         tail     <= 1'b0;
         msg_done <= 1'b0;
         data     <= '0;
      end else begin
         // Markers default low; only an emitted beat raises them.
         valid    <= 1'b0;
         head     <= 1'b0;
         tail     <= 1'b0;
         msg_done <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               if (req_valid) begin
                  hdr_r    <= req_hdr;
                  remain_r <= req_len;
                  csum_r   <= req_hdr;
                  state_r  <= ST_HEAD;
               end else begin
                  state_r  <= ST_IDLE;
               end
            end
            ST_HEAD: begin
               if (!out_hold) begin
                  valid   <= 1'b1;
                  head    <= 1'b1;
                  data    <= hdr_r;
                  state_r <= (remain_r != '0) ? ST_DATA : ST_TAIL;
               end else begin
                  state_r <= ST_HEAD;
               end
            end
            ST_DATA: begin
               if (pop_s) begin
                  valid    <= 1'b1;
                  data     <= pay_data;
                  csum_r   <= csum_r ^ pay_data;
                  remain_r <= remain_r - LEN_ONE;
                  state_r  <= (remain_r == LEN_ONE) ? ST_TAIL : ST_DATA;
               end else begin
                  state_r  <= ST_DATA;
               end
            end
            ST_TAIL: begin
               if (!out_hold) begin
                  valid    <= 1'b1;
                  tail     <= 1'b1;
                  msg_done <= 1'b1;
                  data     <= csum_r;
                  gap_r    <= GAP_LOAD;
                  state_r  <= (GAP_CYCLES > 0) ? ST_GAP : ST_IDLE;
               end else begin
                  state_r  <= ST_TAIL;
               end
            end
            ST_GAP: begin
               if (gap_r == 4'd0) begin
                  state_r <= ST_IDLE;
               end else begin
                  gap_r   <= gap_r - 4'd1;
                  state_r <= ST_GAP;
               end
            end
            default: begin
               state_r <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_msg_framer.sv
// Directed self-checking bench for msg_framer: two instances, one with no
// inter-message gap and one with a three-cycle gap.
module tb_msg_framer;

   logic       clock = 1'b0;
   logic       reset;
   logic       req_valid;
   logic [7:0] req_hdr;
   logic [3:0] req_len;
   logic       pay_valid;
   logic [7:0] pay_data;
   logic       out_hold;

   logic       req_ready, pay_ready, valid, head, tail, msg_done;
   logic [7:0] data;
   logic       g_req_ready, g_pay_ready, g_valid, g_head, g_tail, g_msg_done;
   logic [7:0] g_data;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clock = ~clock;

   msg_framer #(.DATA_WIDTH(8), .LEN_WIDTH(4), .GAP_CYCLES(0)) dut (
      .clock(clock), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_hdr(req_hdr), .req_len(req_len),
      .pay_valid(pay_valid), .pay_ready(pay_ready), .pay_data(pay_data),
      .out_hold(out_hold),
      .valid(valid), .head(head), .tail(tail), .data(data), .msg_done(msg_done)
   );

   msg_framer #(.DATA_WIDTH(8), .LEN_WIDTH(4), .GAP_CYCLES(3)) dut_g (
      .clock(clock), .reset(reset),
      .req_valid(req_valid), .req_ready(g_req_ready), .req_hdr(req_hdr), .req_len(req_len),
      .pay_valid(pay_valid), .pay_ready(g_pay_ready), .pay_data(pay_data),
      .out_hold(out_hold),
      .valid(g_valid), .head(g_head), .tail(g_tail), .data(g_data), .msg_done(g_msg_done)
   );

   // Single comparison point: count it, report any mismatch.
   task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Beat word packs {valid, head, tail, msg_done, data}.
   task automatic chk_beat(input string tag, input logic v, input logic h, input logic t,
                           input logic d, input logic [7:0] dat);
      chk_eq(tag, {20'd0, valid, head, tail, msg_done, data}, {20'd0, v, h, t, d, dat});
   endtask

   task automatic chk_gbeat(input string tag, input logic v, input logic h, input logic t,
                            input logic d, input logic [7:0] dat);
      chk_eq(tag, {20'd0, g_valid, g_head, g_tail, g_msg_done, g_data}, {20'd0, v, h, t, d, dat});
   endtask

   // Advance one clock and settle just after the edge.
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic do_reset(input int cycles);
      reset = 1'b1;
      for (int i = 0; i < cycles; i++) tick();
      reset = 1'b0;
   endtask

   initial begin
      int beats;
      reset = 1'b1; req_valid = 1'b0; req_hdr = 8'h00; req_len = 4'd0;
      pay_valid = 1'b0; pay_data = 8'h00; out_hold = 1'b0;
      #1;
      do_reset(2);

      // Reset state
      chk_beat("reset_out", 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
      chk_eq("reset_req_ready", {31'd0, req_ready}, 32'd1);
      chk_eq("reset_pay_ready", {31'd0, pay_ready}, 32'd0);

      // Basic message A5, len 2, payload 01 02
      req_valid = 1'b1; req_hdr = 8'hA5; req_len = 4'd2; pay_valid = 1'b1; pay_data = 8'h01;
      tick();
      req_valid = 1'b0;
      chk_eq("basic_ready_after_accept", {31'd0, req_ready}, 32'd0);
      chk_eq("basic_pay_ready_head", {31'd0, pay_ready}, 32'd0);
      tick(); chk_beat("basic_head", 1'b1, 1'b1, 1'b0, 1'b0, 8'hA5);
      tick(); chk_beat("basic_d0", 1'b1, 1'b0, 1'b0, 1'b0, 8'h01);
      pay_data = 8'h02;
      tick(); chk_beat("basic_d1", 1'b1, 1'b0, 1'b0, 1'b0, 8'h02);
      chk_eq("basic_ready_in_tail", {31'd0, req_ready}, 32'd0);
      pay_valid = 1'b0;
      tick(); chk_beat("basic_tail", 1'b1, 1'b0, 1'b1, 1'b1, 8'hA6);
      chk_eq("basic_ready_after_tail", {31'd0, req_ready}, 32'd1);
      tick(); chk_beat("basic_idle", 1'b0, 1'b0, 1'b0, 1'b0, 8'hA6);

      // Zero length
      req_valid = 1'b1; req_hdr = 8'h3C; req_len = 4'd0;
      tick(); req_valid = 1'b0;
      chk_eq("zero_pay_ready_a", {31'd0, pay_ready}, 32'd0);
      tick(); chk_beat("zero_head", 1'b1, 1'b1, 1'b0, 1'b0, 8'h3C);
      chk_eq("zero_pay_ready_b", {31'd0, pay_ready}, 32'd0);
      tick(); chk_beat("zero_tail", 1'b1, 1'b0, 1'b1, 1'b1, 8'h3C);

      // Stalls: len 3, payload gap of 2 cycles, one-cycle hold in TAIL
      req_valid = 1'b1; req_hdr = 8'h10; req_len = 4'd3;
      tick(); req_valid = 1'b0;
      tick(); chk_beat("stall_head", 1'b1, 1'b1, 1'b0, 1'b0, 8'h10);
      pay_valid = 1'b1; pay_data = 8'h11;
      tick(); chk_beat("stall_d0", 1'b1, 1'b0, 1'b0, 1'b0, 8'h11);
      pay_valid = 1'b0;
      tick(); chk_beat("stall_bubble0", 1'b0, 1'b0, 1'b0, 1'b0, 8'h11);
      tick(); chk_beat("stall_bubble1", 1'b0, 1'b0, 1'b0, 1'b0, 8'h11);
      pay_valid = 1'b1; pay_data = 8'h22;
      tick(); chk_beat("stall_d1", 1'b1, 1'b0, 1'b0, 1'b0, 8'h22);
      pay_data = 8'h33;
      tick(); chk_beat("stall_d2", 1'b1, 1'b0, 1'b0, 1'b0, 8'h33);
      pay_valid = 1'b0; out_hold = 1'b1;
      tick(); chk_beat("stall_tail_held", 1'b0, 1'b0, 1'b0, 1'b0, 8'h33);
      out_hold = 1'b0;
      tick(); chk_beat("stall_tail", 1'b1, 1'b0, 1'b1, 1'b1, 8'h10);

      // Back-to-back, GAP_CYCLES=0: second head two cycles after first tail
      do_reset(1);
      req_valid = 1'b1; req_hdr = 8'h40; req_len = 4'd0;
      tick(); req_hdr = 8'h50;
      tick(); chk_beat("b2b_head0", 1'b1, 1'b1, 1'b0, 1'b0, 8'h40);
      tick(); chk_beat("b2b_tail0", 1'b1, 1'b0, 1'b1, 1'b1, 8'h40);
      tick(); chk_beat("b2b_gap1", 1'b0, 1'b0, 1'b0, 1'b0, 8'h40);
      tick(); chk_beat("b2b_head1", 1'b1, 1'b1, 1'b0, 1'b0, 8'h50);
      req_valid = 1'b0;
      tick(); chk_beat("b2b_tail1", 1'b1, 1'b0, 1'b1, 1'b1, 8'h50);

      // Back-to-back, GAP_CYCLES=3: second head five cycles after first tail
      do_reset(1);
      req_valid = 1'b1; req_hdr = 8'h40; req_len = 4'd0;
      tick(); req_hdr = 8'h50;
      tick(); chk_gbeat("gap_head0", 1'b1, 1'b1, 1'b0, 1'b0, 8'h40);
      tick(); chk_gbeat("gap_tail0", 1'b1, 1'b0, 1'b1, 1'b1, 8'h40);
      for (int i = 1; i <= 4; i++) begin
         tick();
         chk_gbeat($sformatf("gap_idle%0d", i), 1'b0, 1'b0, 1'b0, 1'b0, 8'h40);
         chk_eq($sformatf("gap_ready%0d", i), {31'd0, g_req_ready}, (i == 3) ? 32'd1 : 32'd0);
      end
      tick(); chk_gbeat("gap_head1", 1'b1, 1'b1, 1'b0, 1'b0, 8'h50);
      req_valid = 1'b0;
      tick(); chk_gbeat("gap_tail1", 1'b1, 1'b0, 1'b1, 1'b1, 8'h50);

      // Reset mid-DATA after the second data beat of a len=4 message
      do_reset(1);
      req_valid = 1'b1; req_hdr = 8'h77; req_len = 4'd4;
      tick(); req_valid = 1'b0;
      tick(); chk_beat("abort_head", 1'b1, 1'b1, 1'b0, 1'b0, 8'h77);
      pay_valid = 1'b1; pay_data = 8'h01;
      tick(); chk_beat("abort_d0", 1'b1, 1'b0, 1'b0, 1'b0, 8'h01);
      pay_data = 8'h02;
      tick(); chk_beat("abort_d1", 1'b1, 1'b0, 1'b0, 1'b0, 8'h02);
      do_reset(1);
      chk_beat("abort_cleared", 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
      chk_eq("abort_req_ready", {31'd0, req_ready}, 32'd1);
      beats = 0;
      for (int i = 0; i < 4; i++) begin
         tick();
         if (valid) beats++;
      end
      chk_eq("abort_no_more_beats", beats, 32'd0);
      pay_valid = 1'b0;
      req_valid = 1'b1; req_hdr = 8'h5A; req_len = 4'd1;
      tick(); req_valid = 1'b0;
      tick(); chk_beat("fresh_head", 1'b1, 1'b1, 1'b0, 1'b0, 8'h5A);
      pay_valid = 1'b1; pay_data = 8'hFF;
      tick(); chk_beat("fresh_d0", 1'b1, 1'b0, 1'b0, 1'b0, 8'hFF);
      pay_valid = 1'b0;
      tick(); chk_beat("fresh_tail", 1'b1, 1'b0, 1'b1, 1'b1, 8'hA5);

      // Max length: 15 payload bytes 1..15, XOR of them is 0, tail = header
      req_valid = 1'b1; req_hdr = 8'h81; req_len = 4'd15;
      tick(); req_valid = 1'b0;
      pay_valid = 1'b1; pay_data = 8'h01;
      beats = 0;
      for (int i = 0; i < 17; i++) begin
         tick();
         if (valid) beats++;
         if (i == 0)
            chk_beat("max_head", 1'b1, 1'b1, 1'b0, 1'b0, 8'h81);
         else if (i == 16)
            chk_beat("max_tail", 1'b1, 1'b0, 1'b1, 1'b1, 8'h81);
         else begin
            chk_beat($sformatf("max_d%0d", i), 1'b1, 1'b0, 1'b0, 1'b0, 8'(i));
            pay_data = 8'(i + 1);
         end
      end
      pay_valid = 1'b0;
      chk_eq("max_beat_count", beats, 32'd17);
      tick(); chk_beat("max_after", 1'b0, 1'b0, 1'b0, 1'b0, 8'h81);
      chk_eq("max_ready_after", {31'd0, req_ready}, 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
